alu_iter_ctrl: RTL and testbench
================================

ALU_ITER_CTRL -- requirements
Module: alu_iter_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: init_a  input  32  signed seed for first operand.
REQ-006 SHALL have port: init_b  input  32  signed seed for second operand.
REQ-007 SHALL have port: op  input  5  ALU operation code, latched on start.
REQ-008 SHALL have port: iter_cnt  input  8  number of ALU iterations, latched on start.
REQ-009 SHALL have port: alu_a  output  32  signed operand A to the downstream ALU chain.
REQ-010 SHALL have port: alu_b  output  32  signed operand B to the downstream ALU chain.
REQ-011 SHALL have port: alu_op  output  5  operation code to the ALU chain.
REQ-012 SHALL have port: alu_out  input  32  combinational ALU chain result.
REQ-013 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: result  output  32  final operand B, held until next start.
REQ-016 SHALL have port: step  output  8  iterations completed so far.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE with start=1 SHALL load alu_a<=init_a, alu_b<=init_b, alu_op<=op, count<=iter_cnt, step<=0.
REQ-019 From IDLE, start with iter_cnt!=0 SHALL go to RUN; with iter_cnt==0 SHALL go to DONE with result<=init_b.
REQ-020 Each RUN cycle SHALL update alu_a<=alu_b, alu_b<=alu_out, step<=step+1.
REQ-021 RUN SHALL go to DONE in the cycle step+1==count, writing result<=alu_out.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-023 Latency SHALL be iter_cnt+1 cycles from the start-sampling edge to done high, or 1 cycle when iter_cnt==0.
REQ-024 start in RUN or DONE SHALL be ignored and never queued.
REQ-025 Changes to init_a/init_b/op/iter_cnt after start SHALL not affect the running sequence.
REQ-026 Arithmetic SHALL be the ALU's. alu_out is taken unmodified, with 32-bit wrap and no saturation.
REQ-027 step SHALL never wrap, because its maximum is 255 == max iter_cnt.
REQ-028 result SHALL be unchanged except at DONE entry.
REQ-029 busy SHALL be low in IDLE and high in RUN and DONE.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear alu_a, alu_b, alu_op, result, step, busy, done to 0, including mid-RUN.
REQ-031 rst SHALL take priority over start and abort in the same cycle.
REQ-032 An aborted or reset sequence SHALL not produce done.

Configuration
REQ-033 Macro ALU_ITER_ABORT_EN defined SHALL add port abort (input, 1).
REQ-034 With ALU_ITER_ABORT_EN, abort=1 in RUN SHALL return to IDLE next cycle with result unchanged and done not pulsed.
REQ-035 With ALU_ITER_ABORT_EN, abort SHALL be ignored in IDLE and DONE.
REQ-036 With ALU_ITER_ABORT_EN undefined, there SHALL be no abort port and behaviour per REQ-017..029.

Structure
REQ-037 Package alu_iter_pkg SHALL hold the state enum, DATA_W=32, OP_W=5, CNT_W=8, and ALU op-code constants, including ALU_ADD.
REQ-038 The 8-bit step counter with terminal detect SHALL be sub-module iter_counter.
REQ-039 The ALU chain itself SHALL stay outside this block, connected via alu_a/alu_b/alu_op/alu_out.

Verification
REQ-040 Fibonacci: init_a=1, init_b=1, op=ALU_ADD, iter_cnt=5 -> done 6 cycles after start, result=13, step=5.
REQ-041 iter_cnt=0, init_b=0x1234 -> done 1 cycle after start, result=0x1234, alu_out ignored.
REQ-042 Wrap: init_a=0x7FFFFFFF, init_b=1, ALU_ADD, iter_cnt=1 -> result=0x80000000.
REQ-043 Second start pulsed at step=2 of a 5-step run -> ignored; exactly one done.
REQ-044 rst at step=3 of a 5-step run -> next cycle all outputs 0, no done; a fresh start runs normally.
REQ-045 With ALU_ITER_ABORT_EN, abort at step=2 -> IDLE, no done, result retains previous value.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg -- shared definitions for the iterative ALU sequencer.
//   DATA_W / OP_W / CNT_W : operand, op-code and iteration counter widths
//   state_e               : sequencer states (IDLE, RUN, DONE)
//   ALU_*                 : op-code constants understood by the downstream ALU chain
package alu_iter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 5'd4;

endpackage

// File: rtl/iter_counter.sv
// iter_counter -- iteration step counter with terminal detect.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears step and terminal count
//   load : clear step and capture the terminal count from term
//   term : terminal iteration count (captured on load)
//   inc  : advance step by one
//   step : iterations completed so far
//   last : high when the current increment is the final one (step+1 == term)
module iter_counter
    import alu_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] term,
    input  logic             inc,
    output logic [CNT_W-1:0] step,
    output logic             last
);

    logic [CNT_W-1:0] term_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= '0;
            term_q <= '0;
        end else if (load) begin
            step   <= '0;
            term_q <= term;
        end else if (inc) begin
            step <= step + CNT_W'(1);
        end
    end

    // Compare one bit wider so step+1 at step=255 cannot alias to zero.
    assign last = (({1'b0, step} + (CNT_W+1)'(1)) == {1'b0, term_q});

endmodule

// File: rtl/alu_iter_ctrl.sv
// alu_iter_ctrl -- sequences an external combinational ALU chain for a
// programmable number of iterations: each RUN cycle shifts alu_a<=alu_b and
// alu_b<=alu_out, so a Fibonacci-style recurrence is produced with ALU_ADD.
//   clk, rst          : clock and synchronous active-high reset
//   start             : request, sampled only in IDLE
//   init_a, init_b    : operand seeds, latched on start
//   op, iter_cnt      : op-code and iteration count, latched on start
//   alu_a, alu_b      : operands driven to the ALU chain
//   alu_op            : op-code driven to the ALU chain
//   alu_out           : combinational ALU chain result
//   busy              : high in RUN and DONE
//   done              : one-cycle completion pulse
//   result            : final operand B, held until the next completion
//   step              : iterations completed so far
// Optional feature: define ALU_ITER_ABORT_EN to add the abort input, which
// returns RUN to IDLE without a done pulse and without touching result.
module alu_iter_ctrl
    import alu_iter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
`ifdef ALU_ITER_ABORT_EN
    input  logic                     abort,
`endif
    input  logic signed [DATA_W-1:0] init_a,
    input  logic signed [DATA_W-1:0] init_b,
    input  logic        [OP_W-1:0]   op,
    input  logic        [CNT_W-1:0]  iter_cnt,
    output logic signed [DATA_W-1:0] alu_a,
    output logic signed [DATA_W-1:0] alu_b,
    output logic        [OP_W-1:0]   alu_op,
    input  logic signed [DATA_W-1:0] alu_out,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result,
    output logic        [CNT_W-1:0]  step
);

    state_e state;
    logic   abort_req;
    logic   cnt_load;
    logic   cnt_inc;
    logic   cnt_last;

`ifdef ALU_ITER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only matters in RUN; elsewhere it is simply not looked at.
    assign cnt_load = (state == ST_IDLE) && start;
    assign cnt_inc  = (state == ST_RUN) && !abort_req;

    iter_counter u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .term (iter_cnt),
        .inc  (cnt_inc),
        .step (step),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        alu_a  <= init_a;
                        alu_b  <= init_b;
                        alu_op <= op;
                        busy   <= 1'b1;
                        if (iter_cnt == '0) begin
                            // Zero iterations: the seed itself is the answer.
                            state  <= ST_DONE;
                            result <= init_b;
                            done   <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        alu_a <= alu_b;
                        alu_b <= alu_out;
                        if (cnt_last) begin
                            state  <= ST_DONE;
                            result <= alu_out;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_ctrl.sv
// tb_alu_iter_ctrl -- self-checking bench for alu_iter_ctrl. The bench plays
// the role of the downstream ALU chain and predicts results by iterating the
// operand recurrence directly. Abort scenarios are included when
// ALU_ITER_ABORT_EN is defined.
module tb_alu_iter_ctrl;
    import alu_iter_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
`ifdef ALU_ITER_ABORT_EN
    logic               abort;
`endif
    logic signed [31:0] init_a;
    logic signed [31:0] init_b;
    logic        [4:0]  op;
    logic        [7:0]  iter_cnt;
    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic        [4:0]  alu_op;
    logic signed [31:0] alu_out;
    logic               busy;
    logic               done;
    logic signed [31:0] result;
    logic        [7:0]  step;

    logic alu_garbage;
    int   total;
    int   bad;
    int   done_seen;

    alu_iter_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ALU_ITER_ABORT_EN
        .abort    (abort),
`endif
        .init_a   (init_a),
        .init_b   (init_b),
        .op       (op),
        .iter_cnt (iter_cnt),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU chain driven by the bench.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] o);
        case (o)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_out = alu_garbage ? 32'hDEAD_BEEF : ref_alu(alu_a, alu_b, alu_op);
    end

    // Count every done pulse seen at a rising edge.
    always @(posedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    // Reference: apply the pair recurrence (a,b) -> (b, a op b) cnt times.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] o, input int cnt,
                                  output logic [31:0] ea, output logic [31:0] eb);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
        x = a;
        y = b;
        for (int i = 0; i < cnt; i++) begin
            t = ref_alu(x, y, o);
            x = y;
            y = t;
        end
        ea = x;
        eb = y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done is seen or the budget runs out; n counts ticks taken.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input logic [4:0] o,
                           input int cnt, input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        int          n;
        int          d0;
        model(a, b, o, cnt, ea, eb);
        d0       = done_seen;
        init_a   = a;
        init_b   = b;
        op       = o;
        iter_cnt = 8'(cnt);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        // Inputs moving after start must not disturb the sequence.
        init_a   = $urandom;
        init_b   = $urandom;
        op       = 5'($urandom_range(0, 4));
        iter_cnt = 8'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(cnt + 5, n);
        check({tag, " latency"}, 32'(n + 1), 32'(cnt + 1));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, result, eb);
        check({tag, " alu_a"}, alu_a, ea);
        check({tag, " alu_b"}, alu_b, eb);
        check({tag, " step"}, 32'(step), 32'(cnt));
        check({tag, " alu_op"}, 32'(alu_op), 32'(o));
        tick();
        check({tag, " done_low"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " held"}, result, eb);
        check({tag, " one_done"}, 32'(done_seen - d0), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        total       = 0;
        bad         = 0;
        done_seen   = 0;
        alu_garbage = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
`ifdef ALU_ITER_ABORT_EN
        abort       = 1'b0;
`endif
        init_a      = '0;
        init_b      = '0;
        op          = '0;
        iter_cnt    = '0;
        tick();
        tick();
        check("rst alu_a", alu_a, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst step", 32'(step), 32'd0);
        check("rst result", result, 32'd0);
        rst = 1'b0;
        tick();

        // Fibonacci.
        run_seq(32'd1, 32'd1, ALU_ADD, 5, "fib");
        check("fib value", result, 32'd13);

        // Zero iterations: alu_out must be ignored.
        alu_garbage = 1'b1;
        run_seq(32'h5555_5555, 32'h0000_1234, ALU_ADD, 0, "zero");
        alu_garbage = 1'b0;
        check("zero value", result, 32'h0000_1234);

        // Signed wrap, no saturation.
        run_seq(32'h7FFF_FFFF, 32'd1, ALU_ADD, 1, "wrap");
        check("wrap value", result, 32'h8000_0000);

        // Second start during RUN is ignored.
        d0       = done_seen;
        init_a   = 32'd1;
        init_b   = 32'd1;
        op       = ALU_ADD;
        iter_cnt = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        check("restart step2", 32'(step), 32'd2);
        init_a   = 32'd99;
        init_b   = 32'd77;
        op       = ALU_XOR;
        iter_cnt = 8'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(10, n);
        check("restart latency", 32'(n + 4), 32'd6);
        check("restart result", result, 32'd13);
        repeat (8) tick();
        check("restart one_done", 32'(done_seen - d0), 32'd1);
        check("restart idle", 32'(busy), 32'd0);

        // Reset mid-RUN.
        d0       = done_seen;
        init_a   = 32'd1;
        init_b   = 32'd1;
        op       = ALU_ADD;
        iter_cnt = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (3) tick();
        check("midrst step3", 32'(step), 32'd3);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("midrst alu_a", alu_a, 32'd0);
        check("midrst alu_b", alu_b, 32'd0);
        check("midrst alu_op", 32'(alu_op), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst step", 32'(step), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        repeat (8) tick();
        check("midrst no_done", 32'(done_seen - d0), 32'd0);
        run_seq(32'd1, 32'd1, ALU_ADD, 5, "post_rst");

`ifdef ALU_ITER_ABORT_EN
        // Abort mid-RUN keeps the previous result and yields no done.
        d0       = done_seen;
        init_a   = 32'd3;
        init_b   = 32'd4;
        op       = ALU_SUB;
        iter_cnt = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        check("abort step2", 32'(step), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", result, 32'd13);
        repeat (8) tick();
        check("abort no_done", 32'(done_seen - d0), 32'd0);
        abort = 1'b1;
        run_seq(32'd2, 32'd3, ALU_ADD, 0, "abort_idle");
        abort = 1'b0;
`endif

        // Randomized sequences.
        for (int k = 0; k < 12; k++) begin
            run_seq($urandom, $urandom, 5'($urandom_range(0, 4)),
                    int'($urandom_range(0, 12)), $sformatf("rnd%0d", k));
        end

        // Longest run: step reaches 255 without wrapping.
        run_seq($urandom, $urandom, ALU_ADD, 255, "max");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
